divider_sequencer: RTL and testbench

- Upstream command/response front end for the Divider.
- Buffers incoming operand pairs in a small FIFO and issues them one at a time to the Divider with a start pulse.
- Waits for the Divider's finished flag, then presents quotient, remainder and undefined on a valid/ready output port.
- Decouples producers and consumers of the Divider from its variable-latency start/finished handshake.

---
 rtl/divider_sequencer.sv | 88 ++++++++
 tb/tb_divider_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/divider_sequencer.sv
// divider_sequencer: buffers operand pairs in a FIFO, issues them to the Divider with a start pulse,
// and returns each result on a valid/ready port in push order.
module divider_sequencer #(
   parameter int N     = 4,
   parameter int DEPTH = 4
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [N-1:0]             i_dividend,
   input  logic [N-1:0]             i_divisor,
   output logic                     o_start,
   output logic [N-1:0]             o_dividend,
   output logic [N-1:0]             o_divisor,
   input  logic                     i_finished,
   input  logic [N-1:0]             i_quotient,
   input  logic [N-1:0]             i_remainder,
   input  logic                     i_undefined,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [N-1:0]             o_quotient,
   output logic [N-1:0]             o_remainder,
   output logic                     o_undefined,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t state, state_next;
   logic [N-1:0] mem_dividend [DEPTH];
   logic [N-1:0] mem_divisor [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic push, pop, capture;
   assign o_ready = o_count != (AW+1)'(DEPTH);
   assign push    = i_valid && o_ready;
   assign pop     = state == IDLE && o_count != '0;
   // finished is only trusted in WAIT; a flag left high from the previous op is ignored in ISSUE
   assign capture = state == WAIT && i_finished && (!o_valid || i_ready);
   always_comb begin
      state_next = state;
      o_start    = 1'b0;
      case (state)
         IDLE:    state_next = pop ? ISSUE : IDLE;
         ISSUE: begin
            o_start    = 1'b1;
            state_next = WAIT;
         end
         WAIT:    state_next = capture ? IDLE : WAIT;
         default: state_next = IDLE;
      endcase
   end
   always_ff @(posedge i_clock) begin
      if (push) begin
         mem_dividend[wr_ptr] <= i_dividend;
         mem_divisor[wr_ptr]  <= i_divisor;
      end
   end
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         o_count     <= '0;
         o_dividend  <= '0;
         o_divisor   <= '0;
         o_valid     <= 1'b0;
         o_quotient  <= '0;
         o_remainder <= '0;
         o_undefined <= 1'b0;
      end else begin
         state <= state_next;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr     <= rd_ptr + 1'b1;
            o_dividend <= mem_dividend[rd_ptr];
            o_divisor  <= mem_divisor[rd_ptr];
         end
         if (push && !pop) o_count <= o_count + 1'b1;
         else if (pop && !push) o_count <= o_count - 1'b1;
         if (capture) begin
            o_valid     <= 1'b1;
            o_quotient  <= i_quotient;
            o_remainder <= i_remainder;
            o_undefined <= i_undefined;
         end else if (i_ready) o_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_divider_sequencer.sv
// tb_divider_sequencer: table-driven scoreboard bench with a behavioural Divider of adjustable latency.
module tb_divider_sequencer;
   localparam int N = 4, DEPTH = 4;
   typedef struct {logic [N-1:0] a, b, q, r; logic u;} vec_t;
   logic i_clock = 0, i_reset = 0, i_valid = 0, i_ready = 1;
   logic [N-1:0] i_dividend = 0, i_divisor = 0;
   logic i_finished, i_undefined;
   logic [N-1:0] i_quotient, i_remainder;
   logic o_ready, o_start, o_valid, o_undefined;
   logic [N-1:0] o_dividend, o_divisor, o_quotient, o_remainder;
   logic [$clog2(DEPTH):0] o_count;
   int errors = 0, checks = 0, starts = 0, lat = 4, s0;
   logic stall = 0;
   logic [3:0] cnt;
   vec_t tv[13];
   vec_t exp_q[$];

   divider_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_dividend(i_dividend), .i_divisor(i_divisor), .o_start(o_start),
      .o_dividend(o_dividend), .o_divisor(o_divisor), .i_finished(i_finished),
      .i_quotient(i_quotient), .i_remainder(i_remainder), .i_undefined(i_undefined),
      .o_valid(o_valid), .i_ready(i_ready), .o_quotient(o_quotient),
      .o_remainder(o_remainder), .o_undefined(o_undefined), .o_count(o_count)
   );

   always #5 i_clock = ~i_clock;

   // Divider model: finishes lat cycles after start (frozen while stall), holds results until next start
   always @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         i_finished <= 0; cnt <= 0; i_quotient <= 0; i_remainder <= 0; i_undefined <= 0;
      end else if (o_start) begin
         i_finished <= 0; cnt <= 4'(lat);
      end else if (cnt != 0 && !stall) begin
         cnt <= cnt - 1;
         if (cnt == 1) begin
            i_finished  <= 1;
            i_quotient  <= (o_divisor == 0) ? '1 : o_dividend / o_divisor;
            i_remainder <= (o_divisor == 0) ? o_dividend : o_dividend % o_divisor;
            i_undefined <= (o_divisor == 0);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge i_clock) begin
      if (i_reset && o_start) starts++;
      if (i_reset && o_valid) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: got q=%0d r=%0d u=%0d expected none", o_quotient, o_remainder, o_undefined);
         end else begin
            chk("res_q", o_quotient, exp_q[0].q);
            chk("res_r", o_remainder, exp_q[0].r);
            chk("res_u", o_undefined, exp_q[0].u);
            if (i_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin @(posedge i_clock); #1; end
   endtask

   task automatic push(input vec_t v);
      bit acc;
      bit done = 0;
      i_valid = 1; i_dividend = v.a; i_divisor = v.b;
      for (int n = 0; n < 400 && !done; n++) begin
         acc = o_ready;
         cyc(1);
         if (acc) begin exp_q.push_back(v); done = 1; end
      end
      i_valid = 0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL push_timeout: got no accept expected accept of %0d/%0d", v.a, v.b);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin cyc(1); n++; end
      chk("drain_left", exp_q.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      tv[0]  = '{4'd13, 4'd3, 4'd4, 4'd1, 1'b0};
      tv[1]  = '{4'd15, 4'd4, 4'd3, 4'd3, 1'b0};
      tv[2]  = '{4'd9,  4'd2, 4'd4, 4'd1, 1'b0};
      tv[3]  = '{4'd7,  4'd7, 4'd1, 4'd0, 1'b0};
      tv[4]  = '{4'd8,  4'd3, 4'd2, 4'd2, 1'b0};
      tv[5]  = '{4'd5,  4'd1, 4'd5, 4'd0, 1'b0};
      tv[6]  = '{4'd6,  4'd0, 4'd15, 4'd6, 1'b1};
      tv[7]  = '{4'd6,  4'd2, 4'd3, 4'd0, 1'b0};
      tv[8]  = '{4'd0,  4'd5, 4'd0, 4'd0, 1'b0};
      tv[9]  = '{4'd15, 4'd15, 4'd1, 4'd0, 1'b0};
      tv[10] = '{4'd15, 4'd1, 4'd15, 4'd0, 1'b0};
      tv[11] = '{4'd10, 4'd3, 4'd3, 4'd1, 1'b0};
      tv[12] = '{4'd12, 4'd5, 4'd2, 4'd2, 1'b0};
      #1;
      chk("rst_ready", o_ready, 1);
      chk("rst_count", o_count, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_start", o_start, 0);
      chk("rst_quot", o_quotient, 0);
      chk("rst_dividend", o_dividend, 0);
      @(posedge i_clock); #1;
      i_reset = 1;
      cyc(1);
      // single op: start in cycle 2 only, result one cycle after finished
      push(tv[0]);
      chk("lat_c1_start", o_start, 0);
      cyc(1);
      chk("lat_c2_start", o_start, 1);
      cyc(1);
      chk("lat_c3_start", o_start, 0);
      for (int n = 0; n < 50 && !i_finished; n++) cyc(1);
      chk("lat_fin_seen", i_finished, 1);
      chk("lat_fin_valid0", o_valid, 0);
      cyc(1);
      chk("lat_valid_f1", o_valid, 1);
      cyc(1);
      chk("lat_valid_clr", o_valid, 0);
      // burst with stalled Divider, sixth pair held off while full
      stall = 1;
      for (int i = 1; i <= 5; i++) push(tv[i]);
      chk("burst_count", o_count, 4);
      chk("burst_ready", o_ready, 0);
      i_valid = 1; i_dividend = tv[12].a; i_divisor = tv[12].b;
      cyc(3);
      chk("burst_held_count", o_count, 4);
      chk("burst_held_ready", o_ready, 0);
      stall = 0;
      push(tv[12]);
      drain();
      // backpressure: first result held, second op waits in WAIT
      lat = 3; i_ready = 0; s0 = starts;
      push(tv[4]);
      push(tv[11]);
      cyc(20);
      chk("bp_starts", starts - s0, 2);
      chk("bp_valid", o_valid, 1);
      chk("bp_held_r", o_remainder, tv[4].r);
      chk("bp_count", o_count, 0);
      i_ready = 1;
      cyc(1);
      chk("bp_next_valid", o_valid, 1);
      chk("bp_next_r", o_remainder, tv[11].r);
      cyc(1);
      chk("bp_clr", o_valid, 0);
      // divide by zero then a normal op
      push(tv[6]);
      push(tv[7]);
      drain();
      // stale finished high across ISSUE must not capture
      lat = 4;
      push(tv[10]);
      cyc(1);
      chk("stale_start", o_start, 1);
      cyc(1);
      chk("stale_no_capture", o_valid, 0);
      drain();
      // reset in WAIT with three queued entries
      stall = 1;
      for (int i = 0; i < 4; i++) push(tv[i]);
      chk("pre_rst_count", o_count, 3);
      i_reset = 0;
      #1;
      chk("arst_count", o_count, 0);
      chk("arst_valid", o_valid, 0);
      chk("arst_start", o_start, 0);
      chk("arst_ready", o_ready, 1);
      exp_q.delete();
      @(posedge i_clock); #1;
      i_reset = 1; stall = 0;
      cyc(1);
      push(tv[11]);
      drain();
      // streaming table with varying latency and downstream stalls
      for (int i = 0; i < 13; i++) begin
         lat = 1 + (i % 4);
         i_ready = (i % 3 != 2);
         push(tv[i]);
      end
      i_ready = 1;
      drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
